// File: rtl/red_pitaya_slew_lim.sv
// Dual-channel output slew-rate limiter with bus-programmable step, hold and bypass.
// Optional macro SLEW_LIM_OFFSET_EN adds a saturating per-channel offset stage (reg 0x1C).
module red_pitaya_slew_lim #(
  parameter int unsigned DW = 14,
  parameter int unsigned PW = 16
)(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] dat_a_i,
  input  logic [DW-1:0] dat_b_i,
  output logic [DW-1:0] dat_a_o,
  output logic [DW-1:0] dat_b_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);

  logic [3:0]    ctrl;
  logic [DW-2:0] step_a;
  logic [DW-2:0] step_b;
  logic [PW-1:0] presc;
  logic [PW-1:0] cnt;
  logic          tick;
  logic [DW-1:0] lim_a;
  logic [DW-1:0] lim_b;
  logic [31:0]   off_rd;
  logic [31:0]   rd_mux;
  logic          busy_a;
  logic          busy_b;
  logic [19:0]   addr;

  logic unused_bits;
  assign unused_bits = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};

  assign addr    = sys_addr[19:0];
  assign sys_err = 1'b0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl   <= '0;
      step_a <= '0;
      step_b <= '0;
      presc  <= '0;
    end else if (sys_wen) begin
      case (addr)
        20'h00:  ctrl   <= sys_wdata[3:0];
        20'h04:  step_a <= sys_wdata[DW-2:0];
        20'h08:  step_b <= sys_wdata[DW-2:0];
        20'h0C:  presc  <= sys_wdata[PW-1:0];
        default: ;
      endcase
    end
  end

  assign tick = (cnt == presc);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      cnt <= '0;
    else if ((sys_wen && addr == 20'h0C) || tick)
      cnt <= '0;
    else
      cnt <= cnt + PW'(1);
  end

  // Difference kept in DW+1 bits so a full-scale swing cannot overflow; steps never overshoot.
  function automatic logic [DW-1:0] slew_next(
    input logic [DW-1:0] cur,
    input logic [DW-1:0] tgt,
    input logic [DW-2:0] step,
    input logic          ena,
    input logic          hold,
    input logic          tk
  );
    logic [DW:0] diff;
    logic [DW:0] mag;
    diff = {tgt[DW-1], tgt} - {cur[DW-1], cur};
    mag  = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
    slew_next = cur;
    if (hold)
      slew_next = cur;
    else if (!ena)
      slew_next = tgt;
    else if (tk) begin
      if (mag <= {2'b00, step})
        slew_next = tgt;
      else if (diff[DW])
        slew_next = cur - {1'b0, step};
      else
        slew_next = cur + {1'b0, step};
    end
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lim_a <= '0;
      lim_b <= '0;
    end else begin
      lim_a <= slew_next(lim_a, dat_a_i, step_a, ctrl[0], ctrl[2], tick);
      lim_b <= slew_next(lim_b, dat_b_i, step_b, ctrl[1], ctrl[3], tick);
    end
  end

  assign busy_a = (lim_a != dat_a_i);
  assign busy_b = (lim_b != dat_b_i);

`ifdef SLEW_LIM_OFFSET_EN
  logic [DW-1:0] off_a;
  logic [DW-1:0] off_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      off_a <= '0;
      off_b <= '0;
    end else if (sys_wen && addr == 20'h1C) begin
      off_a <= sys_wdata[DW-1:0];
      off_b <= sys_wdata[16+DW-1:16];
    end
  end

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = s[DW-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_a_o <= '0;
      dat_b_o <= '0;
    end else begin
      dat_a_o <= sat_add(lim_a, off_a);
      dat_b_o <= sat_add(lim_b, off_b);
    end
  end

  assign off_rd = {{(16-DW){off_b[DW-1]}}, off_b, {(16-DW){off_a[DW-1]}}, off_a};
`else
  assign dat_a_o = lim_a;
  assign dat_b_o = lim_b;
  assign off_rd  = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      20'h00:  rd_mux = {28'h0, ctrl};
      20'h04:  rd_mux = {{(33-DW){1'b0}}, step_a};
      20'h08:  rd_mux = {{(33-DW){1'b0}}, step_b};
      20'h0C:  rd_mux = {{(32-PW){1'b0}}, presc};
      20'h10:  rd_mux = {{(32-DW){dat_a_o[DW-1]}}, dat_a_o};
      20'h14:  rd_mux = {{(32-DW){dat_b_o[DW-1]}}, dat_b_o};
      20'h18:  rd_mux = {30'h0, busy_b, busy_a};
      20'h1C:  rd_mux = off_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_slew_lim.sv
// Scoreboard bench for red_pitaya_slew_lim (default build, offset stage disabled).
module tb_red_pitaya_slew_lim;

  localparam int unsigned DW = 14;
  localparam int unsigned PW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [DW-1:0] dat_a_i = '0;
  logic [DW-1:0] dat_b_i = '0;
  logic [DW-1:0] dat_a_o;
  logic [DW-1:0] dat_b_o;
  logic [31:0]   sys_addr = '0;
  logic [31:0]   sys_wdata = '0;
  logic [3:0]    sys_sel = 4'hF;
  logic          sys_wen = 1'b0;
  logic          sys_ren = 1'b0;
  logic [31:0]   sys_rdata;
  logic          sys_err;
  logic          sys_ack;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rdata;
  logic        rack;

  red_pitaya_slew_lim #(.DW(DW), .PW(PW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .dat_a_i(dat_a_i), .dat_b_i(dat_b_i),
    .dat_a_o(dat_a_o), .dat_b_o(dat_b_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    cyc(1);
    sys_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    sys_addr = a;
    sys_ren  = 1'b1;
    cyc(1);
    sys_ren  = 1'b0;
    d   = sys_rdata;
    ack = sys_ack;
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if ({dat_a_o, dat_b_o} !== '0) begin
      n_err++;
      $display("FAIL reset_dat got a=%h b=%h exp 0", dat_a_o, dat_b_o);
    end
    n_vec++;
    if ({sys_ack, sys_err, sys_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_bus got ack=%b err=%b rdata=%h exp 0", sys_ack, sys_err, sys_rdata);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset_mid;
    bus_write(32'h04, 32'h1);
    bus_write(32'h0C, 32'h0);
    bus_write(32'h00, 32'h1);
    dat_a_i = 14'h0100;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(32'(k));
      cyc(1);
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({18'h0, dat_a_o} !== exp_v) begin
        n_err++;
        $display("FAIL ramp1 k=%0d got %h exp %h", k, dat_a_o, exp_v);
      end
    end
    #2 rstn_i = 1'b0;
    dat_a_i = '0;
    #1;
    n_vec++;
    if (dat_a_o !== '0) begin
      n_err++;
      $display("FAIL async_reset got %h exp 0", dat_a_o);
    end
    #1 rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(32'h0);
      bus_read(32'(r * 4), rdata, rack);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (rdata !== exp_v || rack !== 1'b1) begin
        n_err++;
        $display("FAIL reg_after_reset addr=%h got %h ack=%b exp %h", r * 4, rdata, rack, exp_v);
      end
    end
  endtask

  task automatic test_bypass;
    dat_a_i = 14'h1234;
    n_vec++;
    if (dat_a_o !== 14'h0000) begin
      n_err++;
      $display("FAIL bypass_latency got %h exp 0000", dat_a_o);
    end
    exp_q.push_back(32'h1234);
    cyc(1);
    exp_v = exp_q.pop_front();
    n_vec++;
    if ({18'h0, dat_a_o} !== exp_v) begin
      n_err++;
      $display("FAIL bypass got %h exp %h", dat_a_o, exp_v);
    end
    exp_q.push_back(32'h0);
    bus_read(32'h18, rdata, rack);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rdata !== exp_v) begin
      n_err++;
      $display("FAIL bypass_status got %h exp %h", rdata, exp_v);
    end
  endtask

  task automatic test_ramp_presc;
    int e;
    dat_a_i = '0;
    cyc(1);
    bus_write(32'h04, 32'h100);
    bus_write(32'h00, 32'h1);
    bus_write(32'h0C, 32'h3);
    dat_a_i = 14'h0380;
    for (int k = 1; k <= 16; k++) begin
      e = (k / 4) * 32'h100;
      if (e > 32'h380) e = 32'h380;
      exp_q.push_back(32'(e));
      cyc(1);
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({18'h0, dat_a_o} !== exp_v) begin
        n_err++;
        $display("FAIL ramp_presc k=%0d got %h exp %h", k, dat_a_o, exp_v);
      end
    end
    exp_q.push_back(32'h0);
    bus_read(32'h18, rdata, rack);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rdata !== exp_v) begin
      n_err++;
      $display("FAIL ramp_busy got %h exp %h", rdata, exp_v);
    end
  endtask

  task automatic test_fullscale_neg;
    logic [13:0] seq [4];
    seq[0] = 14'h0FFF; seq[1] = 14'h3FFF; seq[2] = 14'h2FFF; seq[3] = 14'h2000;
    dat_b_i = 14'h1FFF;
    cyc(1);
    n_vec++;
    if (dat_b_o !== 14'h1FFF) begin
      n_err++;
      $display("FAIL fs_start got %h exp 1fff", dat_b_o);
    end
    bus_write(32'h08, 32'h1000);
    bus_write(32'h0C, 32'h0);
    bus_write(32'h00, 32'h3);
    dat_b_i = 14'h2000;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({18'h0, seq[k-1]});
      if (k == 3) begin
        bus_read(32'h18, rdata, rack);
        n_vec++;
        if (rdata !== 32'h2) begin
          n_err++;
          $display("FAIL fs_busy got %h exp 00000002", rdata);
        end
      end else begin
        cyc(1);
      end
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({18'h0, dat_b_o} !== exp_v) begin
        n_err++;
        $display("FAIL fs_neg k=%0d got %h exp %h", k, dat_b_o, exp_v);
      end
    end
  endtask

  task automatic test_hold;
    dat_a_i = '0;
    bus_write(32'h00, 32'h7);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h280);
      if (k > 0) cyc(1);
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({18'h0, dat_a_o} !== exp_v) begin
        n_err++;
        $display("FAIL hold k=%0d got %h exp %h", k, dat_a_o, exp_v);
      end
    end
    exp_q.push_back(32'h1);
    bus_read(32'h18, rdata, rack);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rdata !== exp_v) begin
      n_err++;
      $display("FAIL hold_busy got %h exp %h", rdata, exp_v);
    end
    dat_a_i = 14'h0ABC;
    bus_write(32'h00, 32'h0);
    n_vec++;
    if (dat_a_o !== 14'h0280) begin
      n_err++;
      $display("FAIL hold_release_same got %h exp 0280", dat_a_o);
    end
    cyc(1);
    n_vec++;
    if (dat_a_o !== 14'h0ABC) begin
      n_err++;
      $display("FAIL hold_release got %h exp 0abc", dat_a_o);
    end
  endtask

  task automatic test_step_zero;
    bus_write(32'h04, 32'h0);
    bus_write(32'h00, 32'h1);
    dat_a_i = 14'h0100;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h0ABC);
      cyc(1);
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({18'h0, dat_a_o} !== exp_v) begin
        n_err++;
        $display("FAIL step0_freeze k=%0d got %h exp %h", k, dat_a_o, exp_v);
      end
    end
    bus_read(32'h18, rdata, rack);
    n_vec++;
    if (rdata !== 32'h1) begin
      n_err++;
      $display("FAIL step0_busy got %h exp 00000001", rdata);
    end
    bus_write(32'h00, 32'h0);
    cyc(1);
    n_vec++;
    if (dat_a_o !== 14'h0100) begin
      n_err++;
      $display("FAIL ena_off_snap got %h exp 0100", dat_a_o);
    end
  endtask

  task automatic test_bus;
    logic [31:0] addrs [5];
    logic [31:0] exps  [5];
    bus_write(32'h0C, 32'h5);
    n_vec++;
    if (sys_ack !== 1'b1 || sys_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack got ack=%b err=%b exp ack=1 err=0", sys_ack, sys_err);
    end
    cyc(1);
    n_vec++;
    if (sys_ack !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack_pulse got %b exp 0", sys_ack);
    end
    bus_write(32'h10, 32'hFFFF);
    addrs[0] = 32'h0C; exps[0] = 32'h5;
    addrs[1] = 32'h20; exps[1] = 32'h0;
    addrs[2] = 32'h10; exps[2] = 32'h100;
    addrs[3] = 32'h14; exps[3] = 32'hFFFFE000;
    addrs[4] = 32'h1C; exps[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exps[i]);
      bus_read(addrs[i], rdata, rack);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (rdata !== exp_v || rack !== 1'b1 || sys_err !== 1'b0) begin
        n_err++;
        $display("FAIL rd addr=%h got %h ack=%b err=%b exp %h ack=1 err=0", addrs[i], rdata, rack, sys_err, exp_v);
      end
      cyc(1);
      n_vec++;
      if (sys_ack !== 1'b0) begin
        n_err++;
        $display("FAIL rd_ack_pulse addr=%h got %b exp 0", addrs[i], sys_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_bypass();
    test_ramp_presc();
    test_fullscale_neg();
    test_hold();
    test_step_zero();
    dat_b_i = 14'h2000;
    test_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
